// File: rtl/pmunit_cmd_slave_if.sv
// pmunit_cmd_slave_if: AXI4-Lite bundle between the host interconnect and pmunit_cmd_slave.
interface pmunit_cmd_slave_if #(
   parameter int AW = 6,
   parameter int DW = 32
) ();
   logic [AW-1:0]   S_AXI_AWADDR;
   logic [2:0]      S_AXI_AWPROT;
   logic            S_AXI_AWVALID;
   logic            S_AXI_AWREADY;
   logic [DW-1:0]   S_AXI_WDATA;
   logic [DW/8-1:0] S_AXI_WSTRB;
   logic            S_AXI_WVALID;
   logic            S_AXI_WREADY;
   logic [1:0]      S_AXI_BRESP;
   logic            S_AXI_BVALID;
   logic            S_AXI_BREADY;
   logic [AW-1:0]   S_AXI_ARADDR;
   logic [2:0]      S_AXI_ARPROT;
   logic            S_AXI_ARVALID;
   logic            S_AXI_ARREADY;
   logic [DW-1:0]   S_AXI_RDATA;
   logic [1:0]      S_AXI_RRESP;
   logic            S_AXI_RVALID;
   logic            S_AXI_RREADY;
   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/pmunit_cmd_slave.sv
// pmunit_cmd_slave: AXI4-Lite command slave buffering command words for a NearPM unit.
// Optional PMUNIT_CMD_FRAME_CHECK_EN rejects START unless whole commands were pushed.
module pmunit_cmd_slave #(
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int CMD_FIFO_DEPTH     = 8,
   parameter int COMMAND_WORDS      = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   pmunit_cmd_slave_if.slave             s_axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] COMMAND_BUS,
   output logic                          COMMAND_VALID,
   output logic                          START_EXECUTION,
   output logic [C_S_AXI_DATA_WIDTH-1:0] CURRENT_LOG_ADDR,
   output logic [63:0]                   ADDR_OFFSET,
   output logic                          ADDR_OFFSET_VALID,
   input  logic                          PMUNIT_STATE
);
   localparam int PW = $clog2(CMD_FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [DW/8-1:0] s);
      for (int i = 0; i < DW / 8; i++) merge[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
   endfunction
   logic aw_done_q, aw_done_d, w_done_q, w_done_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic cmd_valid_q, cmd_valid_d, start_q, start_d, pending_q, pending_d, off_valid_q, off_valid_d;
   logic [2:0] waddr_q, waddr_d;
   logic [1:0] bresp_q, bresp_d;
   logic [DW/8-1:0] wstrb_q, wstrb_d;
   logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, cmd_q, cmd_d, log_q, log_d, lo_q, lo_d, hi_q, hi_d;
   logic [DW-1:0] mem_q [CMD_FIFO_DEPTH];
   logic [DW-1:0] mem_d [CMD_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic aw_hs, w_hs, ar_hs, wr_do, full, empty, push, pop, flush, start_req, start_ok, fire;
   logic [2:0] ra;
   logic [DW-1:0] status;
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
   localparam int FW = $clog2(COMMAND_WORDS) + 1;
   logic [FW-1:0] frame_q, frame_d;
`endif
   assign s_axi.S_AXI_AWREADY = !aw_done_q && !bvalid_q;
   assign s_axi.S_AXI_WREADY  = !w_done_q && !bvalid_q;
   assign s_axi.S_AXI_ARREADY = !rvalid_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign COMMAND_BUS       = cmd_q;
   assign COMMAND_VALID     = cmd_valid_q;
   assign START_EXECUTION   = start_q;
   assign CURRENT_LOG_ADDR  = log_q;
   assign ADDR_OFFSET       = {hi_q, lo_q};
   assign ADDR_OFFSET_VALID = off_valid_q;
   always_comb begin
      aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
      w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
      ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
      wr_do = aw_done_q && w_done_q;
      full  = count_q == CW'(CMD_FIFO_DEPTH);
      empty = count_q == '0;
      push  = wr_do && waddr_q == 3'd0 && !full;
      flush = wr_do && waddr_q == 3'd1 && wdata_q[1];
      start_req = wr_do && waddr_q == 3'd1 && wdata_q[0];
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
      start_ok = flush || frame_q == '0;
      frame_d  = flush ? '0 : !push ? frame_q : frame_q == FW'(COMMAND_WORDS - 1) ? '0 : frame_q + 1'b1;
`else
      start_ok = 1'b1;
`endif
      pop  = !PMUNIT_STATE && !empty && !flush;
      fire = pending_q && empty && !cmd_valid_q;
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = wdata_q;
      wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
      count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
      cmd_valid_d = pop;
      cmd_d       = pop ? mem_q[rd_ptr_q] : cmd_q;
      pending_d   = (start_req && start_ok) || (!flush && pending_q && !fire);
      start_d     = fire && !flush;
      log_d = wr_do && waddr_q == 3'd2 ? merge(log_q, wdata_q, wstrb_q) : log_q;
      lo_d  = wr_do && waddr_q == 3'd3 ? merge(lo_q, wdata_q, wstrb_q) : lo_q;
      hi_d  = wr_do && waddr_q == 3'd4 ? merge(hi_q, wdata_q, wstrb_q) : hi_q;
      off_valid_d = wr_do && waddr_q == 3'd4;
      // Errors: push into a full FIFO, or START refused by the frame check
      bresp_d  = !wr_do ? bresp_q : ((waddr_q == 3'd0 && full) || (start_req && !start_ok)) ? 2'b10 : 2'b00;
      bvalid_d = wr_do || (bvalid_q && !s_axi.S_AXI_BREADY);
      aw_done_d = !wr_do && (aw_done_q || aw_hs);
      w_done_d  = !wr_do && (w_done_q || w_hs);
      waddr_d = aw_hs ? s_axi.S_AXI_AWADDR[4:2] : waddr_q;
      wdata_d = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
      wstrb_d = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
      ra = s_axi.S_AXI_ARADDR[4:2];
      status = {16'b0, 8'(count_q), 4'b0, pending_q, full, empty, PMUNIT_STATE};
      rdata_d = !ar_hs ? rdata_q : ra == 3'd2 ? log_q : ra == 3'd3 ? lo_q : ra == 3'd4 ? hi_q :
                ra == 3'd5 ? status : '0;
      rvalid_d = ar_hs || (rvalid_q && !s_axi.S_AXI_RREADY);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_done_q <= 1'b0; w_done_q <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
         cmd_valid_q <= 1'b0; start_q <= 1'b0; pending_q <= 1'b0; off_valid_q <= 1'b0;
         waddr_q <= '0; bresp_q <= '0; wstrb_q <= '0; wdata_q <= '0; rdata_q <= '0;
         cmd_q <= '0; log_q <= '0; lo_q <= '0; hi_q <= '0;
         wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
         for (int i = 0; i < CMD_FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
         frame_q <= '0;
`endif
      end else begin
         aw_done_q <= aw_done_d; w_done_q <= w_done_d; bvalid_q <= bvalid_d; rvalid_q <= rvalid_d;
         cmd_valid_q <= cmd_valid_d; start_q <= start_d; pending_q <= pending_d; off_valid_q <= off_valid_d;
         waddr_q <= waddr_d; bresp_q <= bresp_d; wstrb_q <= wstrb_d; wdata_q <= wdata_d; rdata_q <= rdata_d;
         cmd_q <= cmd_d; log_q <= log_d; lo_q <= lo_d; hi_q <= hi_d;
         wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
         mem_q <= mem_d;
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
         frame_q <= frame_d;
`endif
      end
   end
endmodule

// File: tb/tb_pmunit_cmd_slave.sv
// tb_pmunit_cmd_slave: directed AXI4-Lite vectors against pmunit_cmd_slave with hand-computed results.
module tb_pmunit_cmd_slave;
   logic clk = 1'b0, reset = 1'b1, state = 1'b0;
   logic [31:0] command_bus, log_addr;
   logic [63:0] addr_offset;
   logic command_valid, start_exec, off_valid;
   int total = 0, bad = 0;
   int cyc = 0, nw = 0, ns = 0, nov = 0, last_vc = 0, start_cyc = 0;
   logic [31:0] words [256];
   int vc [256];
   pmunit_cmd_slave_if bus ();
   pmunit_cmd_slave dut (
      .clk(clk), .reset(reset), .s_axi(bus),
      .COMMAND_BUS(command_bus), .COMMAND_VALID(command_valid), .START_EXECUTION(start_exec),
      .CURRENT_LOG_ADDR(log_addr), .ADDR_OFFSET(addr_offset), .ADDR_OFFSET_VALID(off_valid),
      .PMUNIT_STATE(state)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc++;
      if (command_valid) begin
         words[nw] = command_bus;
         vc[nw] = cyc;
         last_vc = cyc;
         nw++;
      end
      if (start_exec) begin
         ns++;
         start_cyc = cyc;
      end
      if (off_valid) nov++;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      int n = 0;
      logic aw_hs, w_hs;
      @(negedge clk);
      bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
      while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 50) begin
         aw_hs = bus.S_AXI_AWREADY; w_hs = bus.S_AXI_WREADY;
         @(negedge clk); n++;
         if (aw_hs) bus.S_AXI_AWVALID = 1'b0;
         if (w_hs) bus.S_AXI_WVALID = 1'b0;
      end
      while (!bus.S_AXI_BVALID && n < 50) begin
         @(negedge clk); n++;
      end
      chk("wr_timeout", 64'(n < 50), 64'd1);
      r = bus.S_AXI_BRESP;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask
   task automatic axi_rd(input logic [5:0] a, output logic [31:0] d);
      int n = 0;
      @(negedge clk);
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
      while (!bus.S_AXI_ARREADY && n < 50) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      while (!bus.S_AXI_RVALID && n < 50) begin
         @(negedge clk); n++;
      end
      chk("rd_timeout", 64'(n < 50), 64'd1);
      d = bus.S_AXI_RDATA;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
   endtask
   initial begin
      logic [1:0] r;
      logic [31:0] d;
      int b, s0, o0, n3;
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
      n3 = 5;
`else
      n3 = 3;
`endif
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_cmd_valid", 64'(command_valid), 64'd0);
      chk("rst_offset", addr_offset, 64'd0);
      chk("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
      axi_rd(6'h14, d);
      chk("rst_status", 64'(d), 64'h2);
      // T1: drain while idle
      b = nw;
      for (int i = 0; i < 5; i++) begin
         axi_wr(6'h00, 32'h11 + 32'(i), 4'hF, r);
         chk("t1_bresp", 64'(r), 64'd0);
      end
      repeat (5) @(negedge clk);
      chk("t1_count", 64'(nw - b), 64'd5);
      for (int i = 0; i < 5; i++) chk("t1_word", 64'(words[b + i]), 64'h11 + 64'(i));
      // T2: overfill while busy, then burst drain
      state = 1'b1;
      b = nw;
      for (int i = 0; i < 9; i++) begin
         axi_wr(6'h00, 32'h20 + 32'(i), 4'hF, r);
         chk(i == 8 ? "t2_full_bresp" : "t2_bresp", 64'(r), i == 8 ? 64'd2 : 64'd0);
      end
      axi_rd(6'h14, d);
      chk("t2_status", 64'(d), 64'h805);
      chk("t2_no_drain", 64'(nw - b), 64'd0);
      @(negedge clk); state = 1'b0;
      repeat (15) @(negedge clk);
      chk("t2_count", 64'(nw - b), 64'd8);
      chk("t2_consecutive", 64'(vc[b + 7] - vc[b]), 64'd7);
      for (int i = 0; i < 8; i++) chk("t2_word", 64'(words[b + i]), 64'h20 + 64'(i));
      axi_rd(6'h14, d);
      chk("t2_status_empty", 64'(d), 64'h2);
      // T3: START waits for the queue to drain
      axi_wr(6'h04, 32'h2, 4'hF, r);
      state = 1'b1;
      b = nw; s0 = ns;
      for (int i = 0; i < n3; i++) axi_wr(6'h00, 32'h31 + 32'(i), 4'hF, r);
      axi_wr(6'h04, 32'h1, 4'hF, r);
      chk("t3_start_bresp", 64'(r), 64'd0);
      repeat (5) @(negedge clk);
      chk("t3_no_pulse", 64'(ns - s0), 64'd0);
      axi_rd(6'h14, d);
      chk("t3_status", 64'(d), 64'({8'(n3), 8'h09}));
      @(negedge clk); state = 1'b0;
      repeat (15) @(negedge clk);
      chk("t3_count", 64'(nw - b), 64'(n3));
      chk("t3_last_word", 64'(words[b + n3 - 1]), 64'h30 + 64'(n3));
      chk("t3_one_pulse", 64'(ns - s0), 64'd1);
      chk("t3_pulse_after", 64'(start_cyc > last_vc), 64'd1);
      // T4: offset and log address registers
      o0 = nov;
      axi_wr(6'h0C, 32'hDEADBEEF, 4'hF, r);
      repeat (2) @(negedge clk);
      chk("t4_lo_no_pulse", 64'(nov - o0), 64'd0);
      axi_wr(6'h10, 32'h1, 4'hF, r);
      repeat (2) @(negedge clk);
      chk("t4_hi_pulse", 64'(nov - o0), 64'd1);
      chk("t4_offset", addr_offset, 64'h1_DEADBEEF);
      axi_wr(6'h08, 32'hAAAA5555, 4'h3, r);
      axi_rd(6'h08, d);
      chk("t4_log_strb", 64'(d), 64'h5555);
      chk("t4_log_port", 64'(log_addr), 64'h5555);
      axi_rd(6'h0C, d);
      chk("t4_lo_read", 64'(d), 64'hDEADBEEF);
      axi_rd(6'h18, d);
      chk("t4_unmapped_rd", 64'(d), 64'd0);
      axi_wr(6'h1C, 32'hFFFF, 4'hF, r);
      chk("t4_unmapped_wr", 64'(r), 64'd0);
      // T5: W ahead of AW, response backpressure
      @(negedge clk);
      bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_BREADY = 1'b0;
      @(negedge clk);
      bus.S_AXI_WVALID = 1'b0;
      chk("t5_wready_low", 64'(bus.S_AXI_WREADY), 64'd0);
      @(negedge clk);
      @(negedge clk);
      bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
      chk("t5_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_bvalid_held", 64'(bus.S_AXI_BVALID), 64'd1);
         chk("t5_ready_low", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 64'd0);
      end
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      chk("t5_bvalid_clr", 64'(bus.S_AXI_BVALID), 64'd0);
      chk("t5_lo", addr_offset, 64'h1_12345678);
      bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("t5_rst_bus", 64'(command_bus), 64'd0);
      chk("t5_rst_log", 64'(log_addr), 64'd0);
      chk("t5_rst_offset", addr_offset, 64'd0);
      chk("t5_rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_rst_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
      // FLUSH discards queued words
      state = 1'b1;
      axi_wr(6'h00, 32'h55, 4'hF, r);
      axi_wr(6'h00, 32'h56, 4'hF, r);
      axi_wr(6'h04, 32'h2, 4'hF, r);
      axi_rd(6'h14, d);
      chk("flush_status", 64'(d), 64'h3);
`ifdef PMUNIT_CMD_FRAME_CHECK_EN
      // T6: START refused mid-frame
      s0 = ns;
      for (int i = 0; i < 4; i++) axi_wr(6'h00, 32'h60 + 32'(i), 4'hF, r);
      axi_wr(6'h04, 32'h1, 4'hF, r);
      chk("t6_start_slverr", 64'(r), 64'd2);
      axi_rd(6'h14, d);
      chk("t6_status", 64'(d), 64'h401);
      axi_wr(6'h00, 32'h64, 4'hF, r);
      axi_wr(6'h04, 32'h1, 4'hF, r);
      chk("t6_start_ok", 64'(r), 64'd0);
      @(negedge clk); state = 1'b0;
      repeat (15) @(negedge clk);
      chk("t6_pulse", 64'(ns - s0), 64'd1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
